acc_proc_core: RTL

ACC_PROC_CORE -- requirements
Module: acc_proc_core

---
 rtl/acc_proc_core.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/acc_proc_core.sv
// acc_proc_core: accumulator CPU core with register file and
// optional shift-add multiplier.
//
// Optional feature macro: ACC_PROC_MUL_EN
//   defined   -> opcode 0x3 runs a DATA_W-cycle unsigned multiply
//   undefined -> opcode 0x3 is a NOP; no MUL state, busy tied to 0
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   instr           {opcode[3:0], operand n[OPD_W-1:0]}
//   instr_valid     instruction presented
//   instr_ready     core can accept (EXEC state)
//   program_counter address of next instruction
//   ACC / EXT       accumulator / multiply high half
//   CorB            carry/borrow flag
//   busy / halted   multiply running / core halted
module acc_proc_core #(
  parameter int DATA_W = 8,
  parameter int OPD_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3+OPD_W:0]  instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [OPD_W-1:0]  program_counter,
  output logic [DATA_W-1:0] ACC,
  output logic [DATA_W-1:0] EXT,
  output logic              CorB,
  output logic              busy,
  output logic              halted
);

  localparam int NREG = 2**OPD_W;

  typedef enum logic [1:0] {
    S_EXEC = 2'd0,
    S_HALT = 2'd1
`ifdef ACC_PROC_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_t;

  state_t state_q, state_d;
  logic [OPD_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ext_q, ext_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic              rf_we;

  logic [3:0]        op;
  logic [OPD_W-1:0]  n;
  logic [DATA_W-1:0] rn;

  assign op = instr[3+OPD_W:OPD_W];
  assign n  = instr[OPD_W-1:0];
  assign rn = rf_q[n];

`ifdef ACC_PROC_MUL_EN
  localparam int CNT_W = $clog2(DATA_W+1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplr_q, mplr_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [2*DATA_W-1:0] prod_nx;

  assign prod_nx = prod_q + (mplr_q[0] ? mcand_q : '0);
  assign busy    = (state_q == S_MUL);
`else
  assign busy    = 1'b0;
`endif

  assign instr_ready     = (state_q == S_EXEC);
  assign halted          = (state_q == S_HALT);
  assign program_counter = pc_q;
  assign ACC             = acc_q;
  assign EXT             = ext_q;
  assign CorB            = c_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ext_d   = ext_q;
    c_d     = c_q;
    rf_we   = 1'b0;
`ifdef ACC_PROC_MUL_EN
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
`endif
    unique case (state_q)
      S_EXEC: begin
        if (instr_valid) begin
          pc_d = pc_q + 1'b1;
          case (op)
            4'h0: begin
              case (n)
                OPD_W'(1): begin
                  c_d   = acc_q[DATA_W-1];
                  acc_d = acc_q << 1;
                end
                OPD_W'(2): begin
                  c_d   = acc_q[0];
                  acc_d = acc_q >> 1;
                end
                OPD_W'(3): begin
                  c_d   = acc_q[0];
                  acc_d = {acc_q[0], acc_q[DATA_W-1:1]};
                end
                OPD_W'(4): begin
                  c_d   = acc_q[DATA_W-1];
                  acc_d = {acc_q[DATA_W-2:0], acc_q[DATA_W-1]};
                end
                OPD_W'(5): begin
                  c_d   = acc_q[0];
                  acc_d = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
                end
                OPD_W'(6):
                  {c_d, acc_d} = {1'b0, acc_q} + (DATA_W+1)'(1);
                OPD_W'(7):
                  {c_d, acc_d} = {1'b0, acc_q} - (DATA_W+1)'(1);
                default: ;
              endcase
            end
            4'h1: {c_d, acc_d} = {1'b0, acc_q} + {1'b0, rn};
            4'h2: begin
              acc_d = acc_q - rn;
              c_d   = (acc_q < rn);
            end
`ifdef ACC_PROC_MUL_EN
            4'h3: begin
              state_d = S_MUL;
              cnt_d   = '0;
              mcand_d = {{DATA_W{1'b0}}, acc_q};
              mplr_d  = rn;
              prod_d  = '0;
            end
`endif
            4'h5: acc_d = acc_q & rn;
            4'h6: acc_d = acc_q ^ rn;
            4'h7: c_d   = (acc_q < rn);
            4'h8: if (c_q) pc_d = n;
            4'h9: acc_d = rn;
            4'hA: rf_we = 1'b1;
            4'hB: pc_d  = n;
            4'hF: begin
              if (&n) begin
                state_d = S_HALT;
                pc_d    = pc_q;
              end
            end
            default: ;
          endcase
        end
      end
`ifdef ACC_PROC_MUL_EN
      S_MUL: begin
        // One partial product per cycle; the final sum is
        // written straight from prod_nx on the last step.
        prod_d  = prod_nx;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W-1)) begin
          {ext_d, acc_d} = prod_nx;
          state_d        = S_EXEC;
        end
      end
`endif
      S_HALT: ;
      default: state_d = S_EXEC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EXEC;
      pc_q    <= '0;
      acc_q   <= '0;
      ext_q   <= '0;
      c_q     <= 1'b0;
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= DATA_W'(i);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ext_q   <= ext_d;
      c_q     <= c_d;
      if (rf_we)
        rf_q[n] <= acc_q;
    end
  end

`ifdef ACC_PROC_MUL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
    end
  end
`endif

endmodule
